// File: rtl/dht11_emulador_if.sv
// ---------------------------------------------------------------------------
// dht11_emulador_if
//   Groups the data and status signals of the DHT11 emulator.  The single
//   data wire (dht_bus) stays a plain inout port on the emulator because it
//   is an open-drain pad.
//
//   Signals:
//     umidade_int / umidade_dec         humidity bytes to be reported
//     temperatura_int / temperatura_dec temperature bytes to be reported
//     forca_erro                        invert the checksum of the next frame
//     ocupado                           a response frame is on the bus
//     pronto                            one-cycle pulse at frame completion
//     erro_start                        one-cycle pulse on a too-short start
//     contador_leituras                 completed frame count (wraps)
//     db_estado                         current controller state code
//
//   Modports:
//     master - the side that supplies the data (host logic or a bench)
//     slave  - the emulator
// ---------------------------------------------------------------------------
interface dht11_emulador_if;
    logic [7:0] umidade_int;
    logic [7:0] umidade_dec;
    logic [7:0] temperatura_int;
    logic [7:0] temperatura_dec;
    logic       forca_erro;
    logic       ocupado;
    logic       pronto;
    logic       erro_start;
    logic [7:0] contador_leituras;
    logic [3:0] db_estado;

    modport master (
        output umidade_int, umidade_dec, temperatura_int, temperatura_dec,
        output forca_erro,
        input  ocupado, pronto, erro_start, contador_leituras, db_estado
    );

    modport slave (
        input  umidade_int, umidade_dec, temperatura_int, temperatura_dec,
        input  forca_erro,
        output ocupado, pronto, erro_start, contador_leituras, db_estado
    );
endinterface

// File: rtl/dht11_emulador.sv
// ---------------------------------------------------------------------------
// dht11_emulador
//   Responder end of the single-wire DHT11 protocol.  Waits for a host start
//   pulse on dht_bus, then answers with the response preamble and a 40-bit
//   frame {umidade_int, umidade_dec, temperatura_int, temperatura_dec,
//   checksum}, MSB first, using DHT11 bit timing.  The line is open-drain:
//   the block only pulls it low or releases it.
//
//   Ports:
//     clock    in     system clock (CLK_POR_US cycles per microsecond)
//     reset    in     asynchronous, active-high reset
//     dht_bus  inout  open-drain data line, driven 0 or Z
//     io       slave  data bytes, fault injection and status outputs
//
//   State table:
//     state      | meaning
//     OCIOSO     | bus released, waiting for the line to fall
//     MEDE_START | measuring the host low pulse
//     ATRASO     | released, delay before answering
//     RESP_BAIXO | response preamble, line held low
//     RESP_ALTO  | response preamble, line released
//     BIT_BAIXO  | low lead-in of the current bit
//     BIT_ALTO   | released; length encodes the current bit
//     FIM_BAIXO  | end-of-frame low mark
// ---------------------------------------------------------------------------
module dht11_emulador #(
    parameter int CLK_POR_US     = 50,
    parameter int T_START_MIN_US = 18000,
    parameter int T_ATRASO_US    = 30,
    parameter int T_RESP_US      = 80,
    parameter int T_BAIXO_US     = 50,
    parameter int T_ZERO_US      = 27,
    parameter int T_UM_US        = 70
) (
    input  logic            clock,
    input  logic            reset,
    inout  wire             dht_bus,
    dht11_emulador_if.slave io
);

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        MEDE_START = 4'd1,
        ATRASO     = 4'd2,
        RESP_BAIXO = 4'd3,
        RESP_ALTO  = 4'd4,
        BIT_BAIXO  = 4'd5,
        BIT_ALTO   = 4'd6,
        FIM_BAIXO  = 4'd7
    } estado_t;

    localparam logic [23:0] CIC_START  = 24'(T_START_MIN_US * CLK_POR_US);
    localparam logic [23:0] CIC_ATRASO = 24'(T_ATRASO_US * CLK_POR_US);
    localparam logic [23:0] CIC_RESP   = 24'(T_RESP_US * CLK_POR_US);
    localparam logic [23:0] CIC_BAIXO  = 24'(T_BAIXO_US * CLK_POR_US);
    localparam logic [23:0] CIC_ZERO   = 24'(T_ZERO_US * CLK_POR_US);
    localparam logic [23:0] CIC_UM     = 24'(T_UM_US * CLK_POR_US);

    estado_t     estado;
    estado_t     estado_prox;

    logic        bus_meta;
    logic        bus_s;

    logic [23:0] cnt;
    logic [23:0] limite;
    logic        fim_fase;

    logic [39:0] quadro;
    logic [5:0]  indice;
    logic [7:0]  soma;

    logic        trava;
    logic        conclui;
    logic        rejeita;
    logic        drive_low;

    logic        ocupado_r;
    logic        pronto_r;
    logic        erro_r;
    logic [7:0]  leituras;

    // Only ever pull low; the high level comes from the external pull-up.
    assign dht_bus = drive_low ? 1'b0 : 1'bz;

    // Idle line is high, so the synchronizer resets to 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_meta <= 1'b1;
            bus_s    <= 1'b1;
        end else begin
            bus_meta <= dht_bus;
            bus_s    <= bus_meta;
        end
    end

    assign soma = io.umidade_int + io.umidade_dec
                + io.temperatura_int + io.temperatura_dec;

    // Length of the current phase in clock cycles.
    always_comb begin
        limite = '0;
        case (estado)
            ATRASO:     limite = CIC_ATRASO;
            RESP_BAIXO: limite = CIC_RESP;
            RESP_ALTO:  limite = CIC_RESP;
            BIT_BAIXO:  limite = CIC_BAIXO;
            BIT_ALTO:   limite = quadro[indice] ? CIC_UM : CIC_ZERO;
            FIM_BAIXO:  limite = CIC_BAIXO;
            default:    limite = '0;
        endcase
    end

    // cnt counts 0 .. limite-1 inside a phase; the last cycle ends it.
    assign fim_fase = (cnt == limite - 24'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        trava       = 1'b0;
        conclui     = 1'b0;
        rejeita     = 1'b0;
        drive_low   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (!bus_s) estado_prox = MEDE_START;
            end
            MEDE_START: begin
                if (bus_s) begin
                    if (cnt >= CIC_START) begin
                        trava       = 1'b1;
                        estado_prox = ATRASO;
                    end else begin
                        rejeita     = 1'b1;
                        estado_prox = OCIOSO;
                    end
                end
            end
            ATRASO: begin
                if (fim_fase) estado_prox = RESP_BAIXO;
            end
            RESP_BAIXO: begin
                drive_low = 1'b1;
                if (fim_fase) estado_prox = RESP_ALTO;
            end
            RESP_ALTO: begin
                if (fim_fase) estado_prox = BIT_BAIXO;
            end
            BIT_BAIXO: begin
                drive_low = 1'b1;
                if (fim_fase) estado_prox = BIT_ALTO;
            end
            BIT_ALTO: begin
                if (fim_fase) estado_prox = (indice == 6'd0) ? FIM_BAIXO : BIT_BAIXO;
            end
            FIM_BAIXO: begin
                drive_low = 1'b1;
                if (fim_fase) begin
                    conclui     = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            quadro    <= '0;
            indice    <= '0;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b0;
            erro_r    <= 1'b0;
            leituras  <= '0;
        end else begin
            pronto_r <= conclui;
            erro_r   <= rejeita;

            // The start measurement holds at full scale instead of wrapping,
            // so an extremely long host low still counts as a valid start.
            if (estado_prox != estado) begin
                cnt <= '0;
            end else if (estado == MEDE_START) begin
                if (!bus_s && cnt != '1) cnt <= cnt + 24'd1;
            end else if (estado != OCIOSO) begin
                cnt <= cnt + 24'd1;
            end

            // Frame contents are frozen here; later input changes are ignored.
            if (trava) begin
                quadro    <= {io.umidade_int, io.umidade_dec,
                              io.temperatura_int, io.temperatura_dec,
                              soma ^ {8{io.forca_erro}}};
                ocupado_r <= 1'b1;
            end

            if (estado == RESP_ALTO) begin
                indice <= 6'd39;
            end else if (estado == BIT_ALTO && fim_fase && indice != 6'd0) begin
                indice <= indice - 6'd1;
            end

            if (conclui) begin
                ocupado_r <= 1'b0;
                leituras  <= leituras + 8'd1;
            end
        end
    end

    assign io.ocupado           = ocupado_r;
    assign io.pronto            = pronto_r;
    assign io.erro_start        = erro_r;
    assign io.contador_leituras = leituras;
    assign io.db_estado         = estado;

endmodule

// File: tb/tb_dht11_emulador.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_dht11_emulador
//   Bench for the DHT11 emulator with shortened timing parameters so that
//   hundreds of frames fit in a short run.  Expected frames come from the
//   byte/checksum rule; expected waveform segments come from the phase
//   lengths.
// ---------------------------------------------------------------------------
module tb_dht11_emulador;
    localparam int CLK = 1;
    localparam int ST  = 10;
    localparam int ATR = 5;
    localparam int RSP = 3;
    localparam int BX  = 2;
    localparam int ZR  = 1;
    localparam int UM  = 4;

    logic clock      = 1'b0;
    logic reset      = 1'b1;
    logic host_baixo = 1'b0;
    wire  dht_bus;

    int checks   = 0;
    int failures = 0;

    pullup pu_bus (dht_bus);
    assign dht_bus = host_baixo ? 1'b0 : 1'bz;

    dht11_emulador_if io ();

    dht11_emulador #(
        .CLK_POR_US     (CLK),
        .T_START_MIN_US (ST),
        .T_ATRASO_US    (ATR),
        .T_RESP_US      (RSP),
        .T_BAIXO_US     (BX),
        .T_ZERO_US      (ZR),
        .T_UM_US        (UM)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .dht_bus (dht_bus),
        .io      (io)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // pronto and erro_start must be single-cycle and never coincide.
    int   viol = 0;
    logic pronto_ant = 1'b0;
    logic erro_ant   = 1'b0;
    always @(negedge clock) begin
        if (io.pronto && io.erro_start) viol++;
        if (io.pronto && pronto_ant) viol++;
        if (io.erro_start && erro_ant) viol++;
        pronto_ant = io.pronto;
        erro_ant   = io.erro_start;
    end

    task automatic check(input string nome, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    function automatic logic [39:0] modelo(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d,
                                           input logic f);
        int         s;
        logic [7:0] cs;
        s  = int'(a) + int'(b) + int'(c) + int'(d);
        cs = 8'(s % 256);
        if (f) cs = ~cs;
        return {a, b, c, d, cs};
    endfunction

    logic       cap_bus[$];
    logic [3:0] cap_est[$];
    int         cap_pronto;
    int         cap_erro;
    int         cap_ocup;

    task automatic captura(input int budget, input logic para_pronto);
        cap_bus.delete();
        cap_est.delete();
        cap_pronto = 0;
        cap_erro   = 0;
        cap_ocup   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            cap_bus.push_back(dht_bus);
            cap_est.push_back(io.db_estado);
            if (io.ocupado) cap_ocup++;
            if (io.erro_start) cap_erro++;
            if (io.pronto) begin
                cap_pronto++;
                if (para_pronto) break;
            end
        end
    endtask

    task automatic pulso_host(input int baixo);
        @(posedge clock);
        #1 host_baixo = 1'b1;
        repeat (baixo) @(posedge clock);
        #1 host_baixo = 1'b0;
    endtask

    task automatic poe_bytes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input logic f);
        io.umidade_int     = a;
        io.umidade_dec     = b;
        io.temperatura_int = c;
        io.temperatura_dec = d;
        io.forca_erro      = f;
    endtask

    // Run-length compare of the captured line against the phase lengths,
    // then decode the 40 bits from the high-time of each bit.
    task automatic analisa(input logic [39:0] esperado, input string tag);
        int          seg[$];
        int          esp[$];
        int          run;
        int          erros;
        int          prim;
        logic        lvl;
        logic [39:0] dec;
        run = 0;
        lvl = (cap_bus.size() > 0) ? cap_bus[0] : 1'b1;
        foreach (cap_bus[i]) begin
            if (cap_bus[i] == lvl) run++;
            else begin
                seg.push_back(lvl ? run : -run);
                lvl = cap_bus[i];
                run = 1;
            end
        end
        if (run > 0) seg.push_back(lvl ? run : -run);
        check({tag, "_nseg"}, longint'(seg.size() >= 84), 1);
        while (seg.size() < 85) seg.push_back(0);

        // Leading high: the release passes two synchronizer stages and one
        // decision cycle before the delay phase starts.
        esp.push_back(ATR*CLK + 3);
        esp.push_back(-(RSP*CLK));
        esp.push_back(RSP*CLK);
        for (int k = 39; k >= 0; k--) begin
            esp.push_back(-(BX*CLK));
            esp.push_back(esperado[k] ? UM*CLK : ZR*CLK);
        end
        esp.push_back(-(BX*CLK));

        erros = 0;
        prim  = -1;
        for (int i = 0; i < 84; i++) begin
            if (seg[i] != esp[i]) begin
                erros++;
                if (prim < 0) prim = i;
            end
        end
        if (prim >= 0)
            $display("  %s first timing difference at segment %0d: got %0d want %0d",
                     tag, prim, seg[prim], esp[prim]);
        check({tag, "_tempos"}, erros, 0);

        dec = '0;
        for (int k = 0; k < 40; k++)
            dec = {dec[38:0], seg[4 + 2*k] > ((ZR + UM) * CLK) / 2};
        check({tag, "_quadro"}, dec, esperado);
    endtask

    task automatic quadro_completo(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] c, input logic [7:0] d,
                                   input logic f, input int baixo,
                                   input logic [39:0] esperado,
                                   input logic embaralha, input string tag);
        logic [7:0] cont0;
        @(posedge clock);
        #1 poe_bytes(a, b, c, d, f);
        cont0 = io.contador_leituras;
        pulso_host(baixo);
        fork
            captura(3000, 1'b1);
            begin
                if (embaralha) begin
                    repeat (40) @(posedge clock);
                    #1 poe_bytes(8'($urandom), 8'($urandom), 8'($urandom),
                                 8'($urandom), ~f);
                end
            end
        join
        analisa(esperado, tag);
        check({tag, "_pronto"}, cap_pronto, 1);
        check({tag, "_contador"}, io.contador_leituras, 8'(cont0 + 8'd1));
        check({tag, "_ocupado_ativo"}, longint'(cap_ocup > 0), 1);
        check({tag, "_ocupado_fim"}, io.ocupado, 0);
        repeat (3) @(posedge clock);
    endtask

    task automatic pulso_curto(input int baixo, input string tag);
        logic [7:0] cont0;
        int         puxadas;
        int         ativos;
        cont0 = io.contador_leituras;
        pulso_host(baixo);
        captura(40, 1'b0);
        puxadas = 0;
        ativos  = 0;
        foreach (cap_bus[i]) if (cap_bus[i] == 1'b0) puxadas++;
        foreach (cap_est[i]) if (cap_est[i] >= 4'd2) ativos++;
        check({tag, "_erro_start"}, cap_erro, 1);
        check({tag, "_sem_pronto"}, cap_pronto, 0);
        check({tag, "_sem_ocupado"}, cap_ocup, 0);
        check({tag, "_bus_solto"}, puxadas, 0);
        check({tag, "_sem_resposta"}, ativos, 0);
        check({tag, "_contador"}, io.contador_leituras, cont0);
    endtask

    task automatic espera_estado(input logic [3:0] e, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (io.db_estado == e) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        string      nome;
        logic [7:0] ui, ud, ti, td;
        logic       f;
        int         baixo;
        logic       aceita;
        logic [7:0] cs;
    } vetor_t;

    vetor_t tab[7];

    initial begin
        logic        ok;
        logic [7:0]  a, b, c, d, cont0;
        logic        f;
        logic [39:0] bits;
        int          nb, run, timeouts;
        logic [3:0]  ant;

        tab[0] = '{"tp1",       8'h12, 8'h34, 8'h22, 8'h02, 1'b0, 14, 1'b1, 8'h6A};
        tab[1] = '{"tp2",       8'h23, 8'h45, 8'hAA, 8'hB2, 1'b0, 14, 1'b1, 8'hC4};
        tab[2] = '{"tp2_erro",  8'h23, 8'h45, 8'hAA, 8'hB2, 1'b1, 14, 1'b1, 8'h3B};
        tab[3] = '{"curto",     8'h00, 8'h00, 8'h00, 8'h00, 1'b0,  6, 1'b0, 8'h00};
        tab[4] = '{"borda_ok",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 11, 1'b1, 8'hFC};
        tab[5] = '{"misto_inv", 8'h55, 8'hAA, 8'h0F, 8'hF0, 1'b1, 14, 1'b1, 8'h01};
        tab[6] = '{"borda_cur", 8'h11, 8'h22, 8'h33, 8'h44, 1'b0,  9, 1'b0, 8'h00};

        poe_bytes(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_estado",   io.db_estado, 0);
        check("rst_ocupado",  io.ocupado, 0);
        check("rst_pronto",   io.pronto, 0);
        check("rst_erro",     io.erro_start, 0);
        check("rst_contador", io.contador_leituras, 0);
        check("rst_bus",      dht_bus, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);

        foreach (tab[i]) begin
            if (tab[i].aceita) begin
                quadro_completo(tab[i].ui, tab[i].ud, tab[i].ti, tab[i].td, tab[i].f,
                                tab[i].baixo,
                                {tab[i].ui, tab[i].ud, tab[i].ti, tab[i].td, tab[i].cs},
                                1'b0, tab[i].nome);
            end else begin
                @(posedge clock);
                #1 poe_bytes(tab[i].ui, tab[i].ud, tab[i].ti, tab[i].td, tab[i].f);
                pulso_curto(tab[i].baixo, tab[i].nome);
            end
        end

        for (int r = 0; r < 12; r++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            d = 8'($urandom);
            f = 1'($urandom);
            quadro_completo(a, b, c, d, f, int'($urandom_range(11, 20)),
                            modelo(a, b, c, d, f), 1'b1, "aleat");
        end

        // Host collision in the middle of bit 20: frame must still complete.
        @(posedge clock);
        #1 poe_bytes(8'h5A, 8'hC3, 8'h96, 8'h0F, 1'b0);
        cont0 = io.contador_leituras;
        pulso_host(14);
        fork
            captura(3000, 1'b1);
            begin
                int entradas;
                logic [3:0] e_ant;
                entradas = 0;
                e_ant    = 4'd0;
                for (int i = 0; i < 3000 && entradas < 20; i++) begin
                    @(negedge clock);
                    if (io.db_estado == 4'd5 && e_ant != 4'd5) entradas++;
                    e_ant = io.db_estado;
                end
                @(posedge clock);
                #1 host_baixo = 1'b1;
                repeat (12) @(posedge clock);
                #1 host_baixo = 1'b0;
            end
        join
        bits = '0;
        nb   = 0;
        run  = 0;
        foreach (cap_est[i]) begin
            if (cap_est[i] == 4'd6) run++;
            else if (run > 0) begin
                bits = {bits[38:0], run == UM*CLK};
                nb++;
                run = 0;
            end
        end
        check("colisao_nbits",    nb, 40);
        check("colisao_quadro",   bits, modelo(8'h5A, 8'hC3, 8'h96, 8'h0F, 1'b0));
        check("colisao_pronto",   cap_pronto, 1);
        check("colisao_contador", io.contador_leituras, 8'(cont0 + 8'd1));
        repeat (4) @(negedge clock);
        check("colisao_ocioso",   io.db_estado, 0);

        // Line held low across the end mark: a new measurement must start,
        // and since the low is short it ends in erro_start.
        @(posedge clock);
        #1 poe_bytes(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        pulso_host(14);
        fork
            captura(3000, 1'b1);
            begin
                logic okf;
                espera_estado(4'd7, 3000, okf);
                @(posedge clock);
                #1 host_baixo = 1'b1;
            end
        join
        check("fim_baixo_pronto", cap_pronto, 1);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (io.db_estado == 4'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("fim_baixo_remede", ok, 1);
        repeat (2) @(posedge clock);
        #1 host_baixo = 1'b0;
        captura(30, 1'b0);
        check("fim_baixo_erro", cap_erro, 1);

        // Reset in BIT_ALTO.
        @(posedge clock);
        #1 poe_bytes(8'hF0, 8'h0F, 8'hAA, 8'h55, 1'b0);
        pulso_host(14);
        espera_estado(4'd6, 3000, ok);
        check("rst_meio_espera", ok, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_meio_estado",   io.db_estado, 0);
        check("rst_meio_ocupado",  io.ocupado, 0);
        check("rst_meio_contador", io.contador_leituras, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        captura(60, 1'b0);
        check("rst_meio_sem_pronto", cap_pronto, 0);

        // Reset while the emulator is pulling low: line released at once.
        pulso_host(14);
        espera_estado(4'd5, 3000, ok);
        check("rst_baixo_espera", ok, 1);
        #2;
        check("rst_baixo_antes", dht_bus, 0);
        reset = 1'b1;
        #1;
        check("rst_baixo_bus", dht_bus, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);

        // 256 back-to-back frames: the counter wraps to zero.
        #1 poe_bytes(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        timeouts = 0;
        for (int n = 0; n < 256; n++) begin
            pulso_host(12);
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clock);
                if (io.pronto) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) timeouts++;
            if (n == 254) check("volta_255", io.contador_leituras, 255);
        end
        check("volta_timeouts", timeouts, 0);
        check("volta_zero", io.contador_leituras, 0);

        check("pulsos_exclusivos", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dht11_emulador.md
Name: dht11_emulador

Overview:
- Synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol.
- Watches the shared `dht_bus` for a host start pulse, then transmits a 40-bit frame with standard DHT11 timing: hum_int, hum_dec, temp_int, temp_dec, checksum.
- Used as an FPGA-side stand-in for the physical sensor so the DHT11 host interface can be exercised in hardware-in-loop and in benches.
- The bus is open-drain: the block only drives 0 or releases to Z. An external or bench pull-up supplies the high level.

Parameters:
- CLK_POR_US, 50, clock cycles per microsecond (50 MHz).
- T_START_MIN_US, 18000, minimum host low time accepted as a start pulse.
- T_ATRASO_US, 30, delay from host release to the start of the response.
- T_RESP_US, 80, duration of each response phase (low, then high).
- T_BAIXO_US, 50, low preamble of each bit and of the end-of-frame mark.
- T_ZERO_US, 27, high time encoding a 0 bit.
- T_UM_US, 70, high time encoding a 1 bit.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- umidade_int  in  8  humidity integer byte.
- umidade_dec  in  8  humidity decimal byte.
- temperatura_int  in  8  temperature integer byte.
- temperatura_dec  in  8  temperature decimal byte.
- forca_erro  in  1  when latched high, the frame's checksum is inverted (fault injection).
- dht_bus  inout  1  open-drain data line; driven 0 or Z only.
- ocupado  out  1  high while a response frame is on the bus.
- pronto  out  1  one-cycle pulse when a frame completes.
- erro_start  out  1  one-cycle pulse when a host low pulse shorter than T_START_MIN_US ends.
- contador_leituras  out  8  count of completed frames; wraps 255 -> 0.
- db_estado  out  4  current FSM state code.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - `reset` asynchronously forces OCIOSO, releases the bus (Z), and clears ocupado, pronto, erro_start, contador_leituras and all counters.
- Bus sampling:
  - `dht_bus` passes through a 2-FF synchronizer; all decisions use the synchronized value `bus_s`.
  - Bus drive expression: 0 when `drive_low` is 1, otherwise Z.
- Timer:
  - Single 24-bit cycle counter.
  - Each phase lasts exactly N*CLK_POR_US cycles, N = that phase's parameter.
  - Counter clears on every state change.
- States:
  - OCIOSO: bus released. On `bus_s` = 0 go to MEDE_START with the counter cleared.
  - MEDE_START: count while `bus_s` = 0; the counter saturates and never wraps. On `bus_s` = 1:
    - count >= T_START_MIN_US*CLK_POR_US: latch the four data bytes and `forca_erro`, compute the checksum, go to ATRASO.
    - otherwise: pulse erro_start, go to OCIOSO.
  - ATRASO: bus released for T_ATRASO_US. ocupado rises on entry.
  - RESP_BAIXO: drive low for T_RESP_US.
  - RESP_ALTO: release for T_RESP_US. Bit index starts at 39.
  - BIT_BAIXO: drive low for T_BAIXO_US.
  - BIT_ALTO: release for T_UM_US if the current bit is 1, T_ZERO_US if it is 0.
    - Index > 0: decrement the index, go to BIT_BAIXO.
    - Index = 0: go to FIM_BAIXO.
  - FIM_BAIXO: drive low for T_BAIXO_US, then go to OCIOSO. In the same cycle: pulse pronto, clear ocupado, increment contador_leituras.
- Frame contents:
  - Bit order MSB first: {umidade_int, umidade_dec, temperatura_int, temperatura_dec, checksum}.
  - checksum = (sum of the four bytes) mod 256, using an 8-bit truncating add. If `forca_erro` is latched, the bitwise inverse is sent.
  - Data inputs are sampled only at the latch point. Changes during a frame do not affect it.
- Bus activity during a response:
  - From ATRASO through FIM_BAIXO, `bus_s` is ignored; host collisions do not abort the frame.
  - If the bus is still low on return to OCIOSO, a new MEDE_START begins the next cycle and measures from there.
- Reset mid-frame: bus released immediately (asynchronous), no pronto pulse, counter not incremented.
- Mutual exclusion: pronto and erro_start can never be high in the same cycle.
- State codes (db_estado):
  - OCIOSO = 0
  - MEDE_START = 1
  - ATRASO = 2
  - RESP_BAIXO = 3
  - RESP_ALTO = 4
  - BIT_BAIXO = 5
  - BIT_ALTO = 6
  - FIM_BAIXO = 7

Test Plan:
1. Bytes 0x12, 0x34, 0x22, 0x02; bench pull-up; host low 18 ms then release -> after 30 us: 80 us low, 80 us high, then 40 bits decoding to 40'h123422026A, checksum 0x6A, 50 us end mark. pronto pulses once; contador_leituras = 1.
2. Bytes 0x23, 0x45, 0xAA, 0xB2 -> checksum 0xC4. Repeat with forca_erro = 1 -> checksum 0x3B; data bytes unchanged.
3. Host low 1 ms then release -> erro_start one-cycle pulse; the emulator never drives dht_bus low; ocupado stays 0; counter unchanged.
4. Per-bit timing on a frame with mixed bits -> each low = 2500 cycles; highs = 1350 cycles (0) and 3500 cycles (1), each ±0 at 50 MHz.
5. Host drives low for 200 us in the middle of bit 20 -> frame completes with correct bits and one pronto; the state machine re-enters MEDE_START only if the line is low at FIM_BAIXO exit.
6. Reset asserted during BIT_ALTO -> dht_bus is Z in the same cycle, db_estado = 0, no pronto. With T_START_MIN_US = 10, 256 back-to-back frames -> contador_leituras wraps to 0.
